// File: rtl/cluster_cmd_arbiter.sv
// Cluster command arbiter: allocates per-core command slots, round-robin arbitrates
// the HPU requests onto the single cluster command path through a one-entry output
// register, and routes completions back to the issuing core.
// Optional build macro: CMD_ARB_PERF_CNT_EN enables the grant/stall performance counters.
module cluster_cmd_arbiter #(
    parameter int unsigned NUM_CORES    = 8,
    parameter int unsigned NUM_HPU_CMDS = 4,
    parameter int unsigned CMD_W        = 608,
    localparam int unsigned CORE_IDW    = $clog2(NUM_CORES),
    localparam int unsigned SLOT_IDW    = $clog2(NUM_HPU_CMDS)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_CORES-1:0]            core_req_valid_i,
    output logic [NUM_CORES-1:0]            core_req_ready_o,
    input  logic [NUM_CORES*CMD_W-1:0]      core_req_cmd_i,
    output logic [NUM_CORES*SLOT_IDW-1:0]   core_req_slot_o,
    output logic                            cmd_valid_o,
    input  logic                            cmd_ready_i,
    output logic [CMD_W-1:0]                cmd_o,
    output logic [CORE_IDW-1:0]             cmd_core_id_o,
    output logic [SLOT_IDW-1:0]             cmd_slot_o,
    input  logic                            resp_valid_i,
    input  logic [CORE_IDW-1:0]             resp_core_id_i,
    input  logic [SLOT_IDW-1:0]             resp_slot_i,
    output logic [NUM_CORES-1:0]            core_resp_valid_o,
    output logic [SLOT_IDW-1:0]             core_resp_slot_o,
    output logic                            spurious_resp_o,
    output logic [31:0]                     perf_grants_o,
    output logic [31:0]                     perf_stalls_o
);

    typedef enum logic {StEmpty, StFull} out_state_e;

    out_state_e                             state_q, state_d;
    logic [NUM_CORES-1:0][NUM_HPU_CMDS-1:0] busy_q, busy_d;
    logic [CORE_IDW-1:0]                    rr_ptr_q, rr_ptr_d;
    logic [CMD_W-1:0]                       cmd_q;
    logic [CORE_IDW-1:0]                    core_id_q;
    logic [SLOT_IDW-1:0]                    slot_q;
    logic [NUM_CORES-1:0]                   core_resp_valid_q;
    logic [SLOT_IDW-1:0]                    core_resp_slot_q;
    logic                                   spurious_q;

    logic [NUM_CORES-1:0][SLOT_IDW-1:0]     free_slot;
    logic [NUM_CORES-1:0]                   eligible;
    logic                                   hi_found, lo_found, grant_any;
    logic [CORE_IDW-1:0]                    hi_idx, lo_idx, winner;
    logic [CMD_W-1:0]                       win_cmd;
    logic                                   out_valid, handshake, load_en, grant, resp_hit;

    assign out_valid = (state_q == StFull);
    assign handshake = out_valid & cmd_ready_i;
    assign load_en   = (state_q == StEmpty) | handshake;

    // Lowest free slot per core from the registered bitmap; a full core is not eligible.
    always_comb begin
        for (int c = 0; c < int'(NUM_CORES); c++) begin
            free_slot[c] = '0;
            for (int s = int'(NUM_HPU_CMDS) - 1; s >= 0; s--) begin
                if (!busy_q[c][s]) begin
                    free_slot[c] = SLOT_IDW'(s);
                end
            end
            eligible[c] = core_req_valid_i[c] & ~(&busy_q[c]);
        end
    end

    assign core_req_slot_o = free_slot;

    // Round-robin pick: lowest eligible index at/after rr_ptr, else lowest overall (wrap).
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int c = int'(NUM_CORES) - 1; c >= 0; c--) begin
            if (eligible[c]) begin
                lo_found = 1'b1;
                lo_idx   = CORE_IDW'(c);
                if (CORE_IDW'(c) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = CORE_IDW'(c);
                end
            end
        end
        grant_any = lo_found;
        winner    = hi_found ? hi_idx : lo_idx;
    end

    // Descriptor mux for the winning core.
    always_comb begin
        win_cmd = '0;
        for (int c = 0; c < int'(NUM_CORES); c++) begin
            if (CORE_IDW'(c) == winner) begin
                win_cmd = core_req_cmd_i[c*CMD_W +: CMD_W];
            end
        end
    end

    // No grants while held in reset, so every output reads 0 during reset.
    assign grant    = load_en & grant_any & rst_ni;
    assign resp_hit = resp_valid_i & busy_q[resp_core_id_i][resp_slot_i];

    // Grant vector: one-hot winner when granting, else all low.
    always_comb begin
        core_req_ready_o = '0;
        if (grant) begin
            core_req_ready_o = NUM_CORES'(1) << winner;
        end
    end

    // Next state for the output stage, round-robin pointer and slot bitmaps.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        busy_d   = busy_q;
        if (grant) begin
            state_d  = StFull;
            rr_ptr_d = (winner == CORE_IDW'(NUM_CORES - 1)) ? '0 : winner + CORE_IDW'(1);
        end else if (handshake) begin
            state_d = StEmpty;
        end
        // A completing slot is busy and a granted slot is free, so these never collide.
        if (resp_hit) begin
            busy_d[resp_core_id_i][resp_slot_i] = 1'b0;
        end
        if (grant) begin
            busy_d[winner][free_slot[winner]] = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StEmpty;
            rr_ptr_q <= '0;
            busy_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
        end
    end

    // Output register: loads on grant, otherwise holds (stable while stalled).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q     <= '0;
            core_id_q <= '0;
            slot_q    <= '0;
        end else if (grant) begin
            cmd_q     <= win_cmd;
            core_id_q <= winner;
            slot_q    <= free_slot[winner];
        end
    end

    // Completion routing: registered one-hot pulse, sticky slot bus, spurious flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            core_resp_valid_q <= '0;
            core_resp_slot_q  <= '0;
            spurious_q        <= 1'b0;
        end else begin
            core_resp_valid_q <= resp_hit ? (NUM_CORES'(1) << resp_core_id_i) : '0;
            spurious_q        <= resp_valid_i & ~resp_hit;
            if (resp_hit) begin
                core_resp_slot_q <= resp_slot_i;
            end
        end
    end

    assign cmd_valid_o       = out_valid;
    assign cmd_o             = cmd_q;
    assign cmd_core_id_o     = core_id_q;
    assign cmd_slot_o        = slot_q;
    assign core_resp_valid_o = core_resp_valid_q;
    assign core_resp_slot_o  = core_resp_slot_q;
    assign spurious_resp_o   = spurious_q;

`ifdef CMD_ARB_PERF_CNT_EN
    logic [31:0] perf_grants_q, perf_stalls_q;

    // Wrapping counters of output handshakes and stalled output cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_grants_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (handshake) begin
                perf_grants_q <= perf_grants_q + 32'd1;
            end
            if (out_valid && !cmd_ready_i) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign perf_grants_o = perf_grants_q;
    assign perf_stalls_o = perf_stalls_q;
`else
    assign perf_grants_o = '0;
    assign perf_stalls_o = '0;
`endif

endmodule

// File: tb/tb_cluster_cmd_arbiter.sv
// Self-checking bench for cluster_cmd_arbiter: expected output commands are queued
// when a grant is observed and compared when the output handshake occurs.
module tb_cluster_cmd_arbiter;

    localparam int NC = 8;
    localparam int CW = 608;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b1;
    logic [NC-1:0]   req_valid = '0;
    logic [NC-1:0]   req_ready;
    logic [NC*CW-1:0] req_cmd = '0;
    logic [NC*2-1:0] req_slot;
    logic            cmd_valid;
    logic            cmd_ready = 1'b0;
    logic [CW-1:0]   cmd;
    logic [2:0]      cmd_core;
    logic [1:0]      cmd_slot;
    logic            resp_valid = 1'b0;
    logic [2:0]      resp_core = '0;
    logic [1:0]      resp_slot = '0;
    logic [NC-1:0]   core_resp_valid;
    logic [1:0]      core_resp_slot;
    logic            spurious;
    logic [31:0]     perf_grants, perf_stalls;

    typedef struct packed {
        logic [2:0]  core;
        logic [1:0]  slot;
        logic [31:0] word;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    cluster_cmd_arbiter dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .core_req_valid_i  (req_valid),
        .core_req_ready_o  (req_ready),
        .core_req_cmd_i    (req_cmd),
        .core_req_slot_o   (req_slot),
        .cmd_valid_o       (cmd_valid),
        .cmd_ready_i       (cmd_ready),
        .cmd_o             (cmd),
        .cmd_core_id_o     (cmd_core),
        .cmd_slot_o        (cmd_slot),
        .resp_valid_i      (resp_valid),
        .resp_core_id_i    (resp_core),
        .resp_slot_i       (resp_slot),
        .core_resp_valid_o (core_resp_valid),
        .core_resp_slot_o  (core_resp_slot),
        .spurious_resp_o   (spurious),
        .perf_grants_o     (perf_grants),
        .perf_stalls_o     (perf_stalls)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(int c, int tag);
        return {8'hA5, 8'(c), 16'(tag)};
    endfunction

    task automatic load_words(int tag);
        for (int c = 0; c < NC; c++) begin
            req_cmd[c*CW +: CW] = {19{word_of(c, tag)}};
        end
    endtask

    task automatic apply_reset();
        req_valid  = '0;
        cmd_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_core  = '0;
        resp_slot  = '0;
        rst_ni     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req_valid = '0;
        rst_ni    = 1'b0;
        #1;
        n_tests++;
        if ({cmd_valid, req_ready, cmd, cmd_core, cmd_slot, core_resp_valid, core_resp_slot,
             spurious, perf_grants, perf_stalls, req_slot} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b ready=%h core=%0d slot=%0d pg=%0d ps=%0d, expected all 0",
                     cmd_valid, req_ready, cmd_core, cmd_slot, perf_grants, perf_stalls);
        end
        apply_reset();
        @(negedge clk);
        n_tests++;
        if (cmd_valid !== 1'b0 || req_slot !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got valid=%b slots=%h, expected 0 and 0", cmd_valid, req_slot);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        int ec, es;
        apply_reset();
        cmd_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            req_valid = (k < 9) ? '1 : '0;
            load_words(k);
            @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rr_out: got unexpected core=%0d slot=%0d, expected none", cmd_core, cmd_slot);
                end else begin
                    e = sb.pop_front();
                    if ({cmd_core, cmd_slot, cmd} !== {e.core, e.slot, {19{e.word}}}) begin
                        n_fail++;
                        $display("FAIL rr_out: got core=%0d slot=%0d word=%h, expected core=%0d slot=%0d word=%h",
                                 cmd_core, cmd_slot, cmd[31:0], e.core, e.slot, e.word);
                    end
                end
            end
            if (k < 9) begin
                ec = k % 8;
                es = k / 8;
                n_tests++;
                if (req_ready !== (8'h01 << ec) || req_slot[ec*2 +: 2] !== 2'(es)) begin
                    n_fail++;
                    $display("FAIL rr_grant: cycle %0d got ready=%h slot=%0d, expected ready=%h slot=%0d",
                             k, req_ready, req_slot[ec*2 +: 2], 8'h01 << ec, es);
                end
                sb.push_back('{core: 3'(ec), slot: 2'(es), word: word_of(ec, k)});
            end
            if (k < 2) begin
                n_tests++;
                if (cmd_valid !== 1'(k)) begin
                    n_fail++;
                    $display("FAIL rr_latency: cycle %0d got cmd_valid=%b, expected %0d", k, cmd_valid, k);
                end
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rr_drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_single_core();
        apply_reset();
        cmd_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_valid = 8'h08;
            load_words(k);
            @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sc_out: got unexpected core=%0d slot=%0d, expected none", cmd_core, cmd_slot);
                end else begin
                    e = sb.pop_front();
                    if ({cmd_core, cmd_slot, cmd} !== {e.core, e.slot, {19{e.word}}}) begin
                        n_fail++;
                        $display("FAIL sc_out: got core=%0d slot=%0d word=%h, expected core=%0d slot=%0d word=%h",
                                 cmd_core, cmd_slot, cmd[31:0], e.core, e.slot, e.word);
                    end
                end
            end
            n_tests++;
            if (k < 4) begin
                if (req_ready !== 8'h08 || req_slot[6 +: 2] !== 2'(k)) begin
                    n_fail++;
                    $display("FAIL sc_alloc: cycle %0d got ready=%h slot=%0d, expected ready=08 slot=%0d",
                             k, req_ready, req_slot[6 +: 2], k);
                end
                sb.push_back('{core: 3'd3, slot: 2'(k), word: word_of(3, k)});
            end else if (req_ready !== 8'h00) begin
                n_fail++;
                $display("FAIL sc_full: cycle %0d got ready=%h, expected 00", k, req_ready);
            end
            @(posedge clk);
            #1;
        end
        resp_valid = 1'b1;
        resp_core  = 3'd3;
        resp_slot  = 2'd2;
        load_words(20);
        @(negedge clk);
        n_tests++;
        if (req_ready !== 8'h00) begin
            n_fail++;
            $display("FAIL sc_resp_cycle: got ready=%h, expected 00", req_ready);
        end
        @(posedge clk);
        #1;
        resp_valid = 1'b0;
        load_words(21);
        @(negedge clk);
        n_tests++;
        if (core_resp_valid !== 8'h08 || core_resp_slot !== 2'd2 || spurious !== 1'b0
            || req_ready !== 8'h08 || req_slot[6 +: 2] !== 2'd2) begin
            n_fail++;
            $display("FAIL sc_reuse: got rv=%h rslot=%0d sp=%b ready=%h slot=%0d, expected rv=08 rslot=2 sp=0 ready=08 slot=2",
                     core_resp_valid, core_resp_slot, spurious, req_ready, req_slot[6 +: 2]);
        end
        sb.push_back('{core: 3'd3, slot: 2'd2, word: word_of(3, 21)});
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        if (cmd_valid && cmd_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sc_out: got unexpected core=%0d slot=%0d, expected none", cmd_core, cmd_slot);
            end else begin
                e = sb.pop_front();
                if ({cmd_core, cmd_slot, cmd} !== {e.core, e.slot, {19{e.word}}}) begin
                    n_fail++;
                    $display("FAIL sc_out: got core=%0d slot=%0d word=%h, expected core=%0d slot=%0d word=%h",
                             cmd_core, cmd_slot, cmd[31:0], e.core, e.slot, e.word);
                end
            end
        end
        n_tests++;
        if (core_resp_valid !== 8'h00 || core_resp_slot !== 2'd2) begin
            n_fail++;
            $display("FAIL sc_resp_hold: got rv=%h rslot=%0d, expected rv=00 rslot=2", core_resp_valid, core_resp_slot);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sc_drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_stall();
        apply_reset();
        cmd_ready = 1'b0;
        req_valid = 8'h02;
        load_words(1);
        @(negedge clk);
        n_tests++;
        if (req_ready !== 8'h02) begin
            n_fail++;
            $display("FAIL st_first: got ready=%h, expected 02", req_ready);
        end
        sb.push_back('{core: 3'd1, slot: 2'd0, word: word_of(1, 1)});
        @(posedge clk);
        #1;
        req_valid = 8'h06;
        load_words(2);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            n_tests++;
            if (req_ready !== 8'h00 || cmd_valid !== 1'b1 || cmd_core !== 3'd1
                || cmd !== {19{word_of(1, 1)}}) begin
                n_fail++;
                $display("FAIL st_hold: stall %0d got ready=%h valid=%b core=%0d word=%h, expected ready=00 valid=1 core=1 word=%h",
                         s, req_ready, cmd_valid, cmd_core, cmd[31:0], word_of(1, 1));
            end
            @(posedge clk);
            #1;
        end
        cmd_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) req_valid = '0;
            @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL st_out: got unexpected core=%0d slot=%0d, expected none", cmd_core, cmd_slot);
                end else begin
                    e = sb.pop_front();
                    if ({cmd_core, cmd_slot, cmd} !== {e.core, e.slot, {19{e.word}}}) begin
                        n_fail++;
                        $display("FAIL st_out: got core=%0d slot=%0d word=%h, expected core=%0d slot=%0d word=%h",
                                 cmd_core, cmd_slot, cmd[31:0], e.core, e.slot, e.word);
                    end
                end
            end
            if (k == 0) begin
                n_tests++;
                if (req_ready !== 8'h04) begin
                    n_fail++;
                    $display("FAIL st_release: got ready=%h, expected 04", req_ready);
                end
                sb.push_back('{core: 3'd2, slot: 2'd0, word: word_of(2, 2)});
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL st_drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_full_core();
        apply_reset();
        cmd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_valid  = (k < 7) ? 8'h20 : 8'h00;
            resp_valid = (k == 5);
            resp_core  = 3'd5;
            resp_slot  = 2'd0;
            load_words(k);
            @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL fc_out: got unexpected core=%0d slot=%0d, expected none", cmd_core, cmd_slot);
                end else begin
                    e = sb.pop_front();
                    if ({cmd_core, cmd_slot, cmd} !== {e.core, e.slot, {19{e.word}}}) begin
                        n_fail++;
                        $display("FAIL fc_out: got core=%0d slot=%0d word=%h, expected core=%0d slot=%0d word=%h",
                                 cmd_core, cmd_slot, cmd[31:0], e.core, e.slot, e.word);
                    end
                end
            end
            if (k < 4 || k == 6) begin
                n_tests++;
                if (req_ready !== 8'h20 || req_slot[10 +: 2] !== ((k == 6) ? 2'd0 : 2'(k))) begin
                    n_fail++;
                    $display("FAIL fc_alloc: cycle %0d got ready=%h slot=%0d, expected ready=20 slot=%0d",
                             k, req_ready, req_slot[10 +: 2], (k == 6) ? 0 : k);
                end
                sb.push_back('{core: 3'd5, slot: (k == 6) ? 2'd0 : 2'(k), word: word_of(5, k)});
            end else if (k == 4 || k == 5) begin
                n_tests++;
                if (req_ready !== 8'h00) begin
                    n_fail++;
                    $display("FAIL fc_blocked: cycle %0d got ready=%h, expected 00", k, req_ready);
                end
            end
            if (k == 6) begin
                n_tests++;
                if (core_resp_valid !== 8'h20) begin
                    n_fail++;
                    $display("FAIL fc_resp: got rv=%h, expected 20", core_resp_valid);
                end
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL fc_drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_spurious();
        apply_reset();
        cmd_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            req_valid  = (k == 0 || k == 5) ? 8'h40 : 8'h00;
            resp_valid = (k == 2);
            resp_core  = 3'd6;
            resp_slot  = 2'd1;
            load_words(k);
            @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sp_out: got unexpected core=%0d slot=%0d, expected none", cmd_core, cmd_slot);
                end else begin
                    e = sb.pop_front();
                    if ({cmd_core, cmd_slot, cmd} !== {e.core, e.slot, {19{e.word}}}) begin
                        n_fail++;
                        $display("FAIL sp_out: got core=%0d slot=%0d word=%h, expected core=%0d slot=%0d word=%h",
                                 cmd_core, cmd_slot, cmd[31:0], e.core, e.slot, e.word);
                    end
                end
            end
            if (k == 0 || k == 5) begin
                n_tests++;
                if (req_ready !== 8'h40 || req_slot[12 +: 2] !== ((k == 0) ? 2'd0 : 2'd1)) begin
                    n_fail++;
                    $display("FAIL sp_alloc: cycle %0d got ready=%h slot=%0d, expected ready=40 slot=%0d",
                             k, req_ready, req_slot[12 +: 2], (k == 0) ? 0 : 1);
                end
                sb.push_back('{core: 3'd6, slot: (k == 0) ? 2'd0 : 2'd1, word: word_of(6, k)});
            end
            if (k >= 2 && k <= 4) begin
                n_tests++;
                if (spurious !== (k == 3) || core_resp_valid !== 8'h00) begin
                    n_fail++;
                    $display("FAIL sp_pulse: cycle %0d got sp=%b rv=%h, expected sp=%0d rv=00",
                             k, spurious, core_resp_valid, (k == 3));
                end
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sp_drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_perf_and_reset();
        logic [31:0] exp_g, exp_s;
`ifdef CMD_ARB_PERF_CNT_EN
        exp_g = 32'd10;
        exp_s = 32'd3;
`else
        exp_g = 32'd0;
        exp_s = 32'd0;
`endif
        apply_reset();
        for (int k = 0; k < 14; k++) begin
            cmd_ready = !(k >= 1 && k <= 3);
            req_valid = (k <= 12) ? 8'hFF : 8'h00;
            load_words(k);
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (perf_grants !== exp_g || perf_stalls !== exp_s) begin
            n_fail++;
            $display("FAIL perf_counts: got grants=%0d stalls=%0d, expected grants=%0d stalls=%0d",
                     perf_grants, perf_stalls, exp_g, exp_s);
        end
        cmd_ready = 1'b1;
        req_valid = 8'hFF;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_ni = 1'b0;
        #1;
        n_tests++;
        if ({cmd_valid, req_ready, cmd, cmd_core, cmd_slot, core_resp_valid, core_resp_slot,
             spurious, perf_grants, perf_stalls, req_slot} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%b ready=%h core=%0d slot=%0d pg=%0d ps=%0d slots=%h, expected all 0",
                     cmd_valid, req_ready, cmd_core, cmd_slot, perf_grants, perf_stalls, req_slot);
        end
        req_valid = '0;
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        load_words(0);
        test_reset();
        test_round_robin();
        test_single_core();
        test_stall();
        test_full_core();
        test_spurious();
        test_perf_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cluster_cmd_arbiter.md
Name: cluster_cmd_arbiter

Overview:
- Shares the single cluster-to-uncluster command path between the NUM_CORES HPUs of one cluster.
- Each HPU may have at most NUM_HPU_CMDS commands outstanding. The block allocates the per-core local command ID, round-robin arbitrates, and registers the winner on the output.
- Completions are routed back to the issuing core and free its ID slot.
- Sits between the HPU drivers and the cluster command port feeding the command unit.

Parameters:
- NUM_CORES, 8, number of requesting HPUs.
- NUM_HPU_CMDS, 4, outstanding-command slots per core.
- CMD_W, 608, width of the opaque command descriptor (19 x 32 b).
- CORE_IDW, $clog2(NUM_CORES), derived core-ID width.
- SLOT_IDW, $clog2(NUM_HPU_CMDS), derived slot-ID width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- core_req_valid_i  in  NUM_CORES  per-core request valid
- core_req_ready_o  out  NUM_CORES  per-core grant (handshake = valid & ready)
- core_req_cmd_i  in  NUM_CORES*CMD_W  per-core descriptor
- core_req_slot_o  out  NUM_CORES*SLOT_IDW  slot allocated to each core, meaningful when its ready is high
- cmd_valid_o  out  1  registered output valid
- cmd_ready_i  in  1  downstream ready
- cmd_o  out  CMD_W  granted descriptor
- cmd_core_id_o  out  CORE_IDW  issuing core
- cmd_slot_o  out  SLOT_IDW  allocated slot
- resp_valid_i  in  1  completion valid; always accepted, no ready
- resp_core_id_i  in  CORE_IDW  completion core
- resp_slot_i  in  SLOT_IDW  completion slot
- core_resp_valid_o  out  NUM_CORES  one-hot completion pulse to a core
- core_resp_slot_o  out  SLOT_IDW  completed slot (shared bus)
- spurious_resp_o  out  1  one-cycle pulse when a completion targets a free slot
- perf_grants_o  out  32  grant counter (optional feature)
- perf_stalls_o  out  32  stall counter (optional feature)

Behaviour:
- Reset values: all outputs 0, busy bitmaps all 0, round-robin pointer 0, output register empty.
- State per core: busy[NUM_HPU_CMDS] bitmap. A core is eligible when core_req_valid_i is high and its bitmap is not full.
- Output stage: one-entry register, states EMPTY and FULL.
  - load_en = EMPTY | (cmd_valid_o & cmd_ready_i).
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY on downstream handshake with no new grant.
  - FULL -> FULL on handshake plus grant in the same cycle.
  - FULL with cmd_ready_i low: hold all output fields stable and grant nothing.
- Arbitration:
  - When load_en is set, grant the first eligible core at or after rr_ptr, wrapping modulo NUM_CORES.
  - Exactly one core_req_ready_o is high per cycle; all are low when nothing is eligible.
  - On grant: rr_ptr <= winner+1 (wraps to 0 after NUM_CORES-1), busy[winner][slot] <= 1, and the output register loads cmd, core ID and slot.
- Latency: request handshake in cycle N, cmd_valid_o high in cycle N+1.
- Slot allocation: lowest-index free slot, computed from the registered bitmap. core_req_slot_o is valid for every core each cycle, combinationally.
- Completion:
  - resp_valid_i with busy[c][s]=1 clears the bit at the next edge.
  - core_resp_valid_o[c] and core_resp_slot_o are registered: they pulse one cycle after resp_valid_i.
  - If busy[c][s]=0, nothing is cleared, no core_resp pulse is issued, and spurious_resp_o pulses one cycle later.
- Simultaneous grant and completion, same core: the freed slot is not reusable in that same cycle; allocation uses pre-edge state. Both updates are applied.
- Full core (all slots busy): ready held low until a completion frees a slot. That core is skipped by the arbiter; other cores proceed.
- Reset mid-operation: all busy bits, the pointer and the output register are cleared immediately (async). Downstream must also be reset, since in-flight IDs are lost.
- core_resp_slot_o holds its last value between pulses.

Optional Feature:
- Macro: CMD_ARB_PERF_CNT_EN
- Defined:
  - perf_grants_o increments on every output handshake (cmd_valid_o & cmd_ready_i).
  - perf_stalls_o increments on every cycle with cmd_valid_o & !cmd_ready_i.
  - Both are 32-bit, wrap at 2^32-1 -> 0, and reset to 0.
- Not defined: both outputs tied to 0; no counter flops.

Test Plan:
- All 8 cores valid continuously, cmd_ready_i=1 -> grants to cores 0,1,...,7,0; cmd_valid_o first high the cycle after the first grant; slots 0,0,...,0 then 1 on the second lap.
- Core 3 alone, issues 4 commands with no completions -> slots 0,1,2,3; 5th request ready low. resp (core 3, slot 2) -> core_resp_valid_o[3] pulses next cycle; the following grant gets slot 2.
- cmd_ready_i=0 for 5 cycles with cores 1 and 2 valid -> cmd_o/cmd_core_id_o stable and no core ready during the stall. Release -> core 2 granted in the same cycle as the core-1 output handshake.
- Core 5 full; resp (5, 0) in the same cycle core 5 requests -> no grant that cycle; granted slot 0 on the next cycle.
- resp (core 6, slot 1) while core 6 idle -> spurious_resp_o pulses one cycle later, no core_resp_valid_o pulse, bitmap unchanged.
- With CMD_ARB_PERF_CNT_EN: 10 handshakes and 3 stalled cycles -> perf_grants_o=10, perf_stalls_o=3. rst_ni low mid-burst -> all outputs 0 asynchronously.
